// File: rtl/mcycle_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine with its sequencing FSM.
// Optional build macro MCYCLE_EARLY_TERM_EN lets a multiply finish once its multiplier runs out.
module mcycle_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Flush,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] acc_final;
  logic [WIDTH-1:0]   opb_step;
  logic               last_iter;
`ifdef MCYCLE_EARLY_TERM_EN
  logic [CntW-1:0]    rem_iters;
`endif

  // One datapath iteration. For divide, acc holds {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    acc_step  = acc_q;
    opb_step  = opb_q;
    if (!op_q) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      opb_step = opb_q >> 1;
    end else if (!div_diff[WIDTH]) begin
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    last_iter = (count_q == CntW'(WIDTH - 1));
    acc_final = acc_step;
`ifdef MCYCLE_EARLY_TERM_EN
    // Skipped iterations would only shift the accumulator right; apply them in one go.
    rem_iters = CntW'(WIDTH - 1) - count_q;
    if (!op_q && (opb_step == '0)) begin
      last_iter = 1'b1;
      acc_final = acc_step >> rem_iters;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (Start) begin
          state_d = StCompute;
          count_d = '0;
          op_d    = MCycleOp;
          opa_d   = Operand1;
          opb_d   = Operand2;
          acc_d   = MCycleOp ? {{WIDTH{1'b0}}, Operand1} : '0;
        end
      end
      StCompute: begin
        acc_d   = acc_step;
        opb_d   = opb_step;
        count_d = count_q + CntW'(1);
        if (last_iter) begin
          state_d = StDone;
          done_d  = 1'b1;
          res1_d  = acc_final[WIDTH-1:0];
          res2_d  = acc_final[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over both a new Start and a completing iteration.
    if (Flush) begin
      state_d = StIdle;
      done_d  = 1'b0;
      res1_d  = res1_q;
      res2_d  = res2_q;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      op_q    <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      done_q  <= done_d;
    end
  end

  assign Busy    = Reset_n & ((Start & ((state_q == StIdle) | (state_q == StDone))) |
                              (state_q == StCompute));
  assign Done    = done_q;
  assign Result1 = res1_q;
  assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_seq.sv
// Self-checking bench for mcycle_seq: directed scenarios plus randomized ops vs. an arithmetic model.
module tb_mcycle_seq;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         Reset_n;
  logic         Start;
  logic         MCycleOp;
  logic         Flush;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;
  logic         Done;

  int checks = 0;
  int errors = 0;

  mcycle_seq #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Flush    (Flush),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected Done cycle relative to the Start cycle.
  function automatic int exp_lat(input logic op, input logic [W-1:0] b);
    int k;
    k = W;
`ifdef MCYCLE_EARLY_TERM_EN
    if (!op) begin
      k = 1;
      for (int i = 0; i < int'(W); i++) if (b[i]) k = i + 1;
    end
`endif
    return k + 1;
  endfunction

  function automatic logic [63:0] exp_res(input logic op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [63:0] p;
    if (!op) p = 64'(a) * 64'(b);
    else if (b == '0) p = {a, {W{1'b1}}};
    else p = {a % b, a / b};
    return p;
  endfunction

  // Issue an op from the current phase and follow it to its Done cycle (returns at that negedge).
  task automatic do_op(input string tag, input logic op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int cyc;
    int gaps;
    int lat;
    logic [63:0] exp;
    lat  = exp_lat(op, b);
    exp  = exp_res(op, a, b);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1;
    chk({tag, ".busy_start"}, 64'(Busy), 64'(1));
    cyc  = 0;
    gaps = 0;
    while (cyc < 100) begin
      @(posedge CLK);
      #1;
      // Start mid-compute must be ignored; operands are scrambled after the issue edge.
      Start    = (cyc == 4 && lat > 8);
      MCycleOp = $urandom_range(0, 1);
      Operand1 = $urandom;
      Operand2 = $urandom;
      @(negedge CLK);
      cyc++;
      if (Done) break;
      if (!Busy) gaps++;
    end
    Start = 1'b0;
    chk({tag, ".done_cycle"}, 64'(cyc), 64'(lat));
    chk({tag, ".busy_gaps"}, 64'(gaps), 64'(0));
    chk({tag, ".busy_done"}, 64'(Busy), 64'(0));
    chk({tag, ".result1"}, 64'(Result1), 64'(exp[W-1:0]));
    chk({tag, ".result2"}, 64'(Result2), 64'(exp[2*W-1:W]));
  endtask

  task automatic idle(input int n);
    Start = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int dones;
    logic op;
    logic [W-1:0] a, b;

    Reset_n = 1'b0; Start = 1'b1; MCycleOp = 1'b0; Flush = 1'b0;
    Operand1 = 32'd3; Operand2 = 32'd4;
    repeat (2) @(negedge CLK);
    chk("reset.busy", 64'(Busy), 64'(0));
    chk("reset.done", 64'(Done), 64'(0));
    chk("reset.r1", 64'(Result1), 64'(0));
    chk("reset.r2", 64'(Result2), 64'(0));
    Start = 1'b0;
    Reset_n = 1'b1;
    idle(1);

    do_op("mul7x6", 1'b0, 32'd7, 32'd6);
    idle(2);
    do_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div100_7_b2b", 1'b1, 32'd100, 32'd7);
    idle(1);
    do_op("div_by0", 1'b1, 32'h1234, 32'd0);
    idle(1);

    // Flush mid-multiply: no Done, results held, next Start runs normally.
    do_op("mul3x3", 1'b0, 32'd3, 32'd3);
    idle(1);
    Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd5; Operand2 = 32'hA5A5_0005;
    dones = 0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge CLK);
      #1;
      Start = 1'b0;
      Flush = (c == 10);
      @(negedge CLK);
      if (Done) dones++;
    end
    chk("flush.no_done", 64'(dones), 64'(0));
    chk("flush.busy", 64'(Busy), 64'(0));
    chk("flush.r1_held", 64'(Result1), 64'(9));
    @(posedge CLK);
    #1;
    do_op("after_flush", 1'b0, 32'd5, 32'd5);
    idle(1);

    // Asynchronous reset in the middle of a divide.
    Start = 1'b1; MCycleOp = 1'b1; Operand1 = 32'hDEAD_BEEF; Operand2 = 32'd17;
    for (int c = 1; c <= 15; c++) begin
      @(posedge CLK);
      #1;
      Start = 1'b0;
    end
    Reset_n = 1'b0;
    #1;
    chk("mid_reset.busy", 64'(Busy), 64'(0));
    chk("mid_reset.done", 64'(Done), 64'(0));
    chk("mid_reset.r1", 64'(Result1), 64'(0));
    chk("mid_reset.r2", 64'(Result2), 64'(0));
    Start = 1'b1;
    repeat (2) @(negedge CLK);
    chk("in_reset.busy", 64'(Busy), 64'(0));
    @(posedge CLK);
    #1;
    Start = 1'b0;
    Reset_n = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_reset.done", 64'(Done), 64'(0));
    chk("post_reset.busy", 64'(Busy), 64'(0));
    do_op("div9_3", 1'b1, 32'd9, 32'd3);
    idle(1);

    do_op("mul16x5", 1'b0, 32'h10, 32'd5);
    idle(1);
    do_op("mulx0", 1'b0, 32'h1234_5678, 32'd0);
    idle(1);

    for (int i = 0; i < 10; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), op, a, b);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
